y86_alu_cc: RTL and testbench

Parametrised, registered Y86 execute-stage ALU with a condition-code register and a valid/ready handshake on both sides. It performs the four Y86 OPq functions (addq, subq, andq, xorq) on WIDTH-bit signed operands. The result is registered, and the ZF/SF/OF flags are optionally latched. The block sits between decode/operand-fetch and memory/write-back, and stalls cleanly under downstream back-pressure.

---
 rtl/y86_alu_cc.sv | 117 +++++++++++
 tb/tb_y86_alu_cc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_alu_cc.sv
// y86_alu_cc: registered Y86 execute-stage ALU (addq/subq/andq/xorq) with a
// {ZF, SF, OF} condition-code register and valid/ready handshakes on both
// sides. A single output register holds one result. in_ready is derived only
// from that register's occupancy and the downstream ready signal.

module y86_alu_cc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [2:0]       cc
);

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_AND = 4'd2,
    FN_XOR = 4'd3
  } alu_fn_e;

  localparam int MSB = WIDTH - 1;

  // Condition codes come up as "last result was zero": ZF=1, SF=0, OF=0.
  localparam logic [2:0] CC_RESET = 3'b100;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             err_q,       err_d;
  logic [2:0]       cc_q,        cc_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic             fn_valid;
  logic             alu_zf;
  logic             alu_sf;

  // The output register can take a new op when it is empty or draining now.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Combinational ALU; subq computes b - a to match Y86 operand order.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    alu_res  = '0;
    alu_of   = 1'b0;
    fn_valid = 1'b1;
    case (ifun)
      FN_ADD: begin
        alu_res = b + a;
        alu_of  = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      FN_SUB: begin
        alu_res = b - a;
        alu_of  = (a[MSB] != b[MSB]) && (alu_res[MSB] != b[MSB]);
      end
      FN_AND: alu_res = a & b;
      FN_XOR: alu_res = a ^ b;
      default: fn_valid = 1'b0;
    endcase
  end

  assign alu_zf = (alu_res == '0);
  assign alu_sf = alu_res[MSB];

  // Next state: load on accept, otherwise clear valid once the consumer drains.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
    cc_d        = cc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = fn_valid ? alu_res : '0;
      err_d       = !fn_valid;
      if (set_cc && fn_valid) begin
        cc_d = {alu_zf, alu_sf, alu_of};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and condition-code registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_y86_alu_cc.sv
// tb_y86_alu_cc: directed checks with hand-computed values on a 64-bit and
// an 8-bit instance, followed by a randomized handshake run on the 64-bit
// instance compared cycle by cycle against a reference model.

module tb_y86_alu_cc;

  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;

  // 64-bit instance
  logic        in_valid, in_ready, set_cc, out_valid, out_ready, err;
  logic [3:0]  ifun;
  logic [63:0] a, b, result;
  logic [2:0]  cc;

  // 8-bit instance
  logic        in_valid8, in_ready8, set_cc8, out_valid8, out_ready8, err8;
  logic [3:0]  ifun8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  cc8;

  int n_checks = 0;
  int n_pass   = 0;

  y86_alu_cc #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ifun(ifun), .a(a), .b(b), .set_cc(set_cc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .cc(cc)
  );

  y86_alu_cc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .ifun(ifun8), .a(a8), .b(b8), .set_cc(set_cc8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .err(err8), .cc(cc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one op with out_ready=1, take the edge, then drop in_valid.
  task automatic do_op(input logic [3:0] f, input logic [63:0] av, input logic [63:0] bv,
                       input logic sc);
    ifun = f; a = av; b = bv; set_cc = sc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Reference: signed overflow taken from a 65-bit sign-extended sum.
  function automatic void ref_op(input logic [3:0] f, input logic [63:0] av,
                                 input logic [63:0] bv, output logic [63:0] r,
                                 output logic e, output logic [2:0] fl);
    logic [64:0] w;
    logic        o;
    e = 1'b0; o = 1'b0; r = '0;
    case (f)
      4'd0: begin w = {bv[63], bv} + {av[63], av}; r = w[63:0]; o = w[64] ^ w[63]; end
      4'd1: begin w = {bv[63], bv} - {av[63], av}; r = w[63:0]; o = w[64] ^ w[63]; end
      4'd2: r = av & bv;
      4'd3: r = av ^ bv;
      default: e = 1'b1;
    endcase
    fl = {r == 64'd0, r[63], o};
  endfunction

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return ONES;
      3: return MAX64;
      4: return MIN64;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic        m_valid, m_err, e, exp_acc;
    logic [63:0] m_res, r;
    logic [2:0]  m_cc, fl;
    int          accepts, cycles;

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; set_cc = 0; ifun = 0; a = 0; b = 0;
    in_valid8 = 0; out_ready8 = 0; set_cc8 = 0; ifun8 = 0; a8 = 0; b8 = 0;

    // 1. reset state, then ADD overflow
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cc", 64'(cc), 64'd4);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    do_op(4'd0, 64'd1, MAX64, 1'b1);
    check("add_ovf_valid", 64'(out_valid), 64'd1);
    check("add_ovf_result", result, MIN64);
    check("add_ovf_cc", 64'(cc), 64'd3);

    // 2. SUB equal, SUB overflow
    do_op(4'd1, 64'd5, 64'd5, 1'b1);
    check("sub_eq_result", result, 64'd0);
    check("sub_eq_cc", 64'(cc), 64'd4);
    do_op(4'd1, 64'd1, MIN64, 1'b1);
    check("sub_ovf_result", result, MAX64);
    check("sub_ovf_cc", 64'(cc), 64'd1);

    // 3. AND / XOR on disjoint operands
    do_op(4'd2, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1);
    check("and_result", result, 64'd0);
    check("and_cc", 64'(cc), 64'd4);
    do_op(4'd3, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1);
    check("xor_result", result, ONES);
    check("xor_cc", 64'(cc), 64'd2);

    // 4. back-pressure: drain, then accept op1 into a stalled consumer
    @(posedge clk); #1;
    check("drain_valid", 64'(out_valid), 64'd0);
    ifun = 4'd0; a = 64'd2; b = 64'd3; set_cc = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_op1_result", result, 64'd5);
    check("bp_op1_cc", 64'(cc), 64'd0);
    ifun = 4'd1; a = 64'd10; b = 64'd3; set_cc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", result, 64'd5);
      check("bp_hold_cc", 64'(cc), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_op2_valid", 64'(out_valid), 64'd1);
    check("bp_op2_result", result, 64'hFFFF_FFFF_FFFF_FFF9);
    check("bp_op2_cc", 64'(cc), 64'd2);
    @(posedge clk); #1;
    check("bp_final_drain", 64'(out_valid), 64'd0);

    // 5. set_cc=0 and invalid ifun leave cc alone
    do_op(4'd3, 64'd5, 64'd5, 1'b0);
    check("nocc_result", result, 64'd0);
    check("nocc_cc", 64'(cc), 64'd2);
    do_op(4'd7, 64'd1, 64'd2, 1'b1);
    check("inv_result", result, 64'd0);
    check("inv_err", 64'(err), 64'd1);
    check("inv_cc", 64'(cc), 64'd2);
    do_op(4'd0, 64'd1, 64'd1, 1'b0);
    check("err_clear", 64'(err), 64'd0);
    check("err_clear_result", result, 64'd2);

    // 6. asynchronous reset mid-stall
    ifun = 4'd1; a = 64'd1; b = 64'd0; set_cc = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_cc", 64'(cc), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_cc", 64'(cc), 64'd4);
    check("async_rst_result", result, 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;

    // narrow width
    ifun8 = 4'd0; a8 = 8'h40; b8 = 8'h40; set_cc8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("w8_add_result", 64'(result8), 64'h80);
    check("w8_add_cc", 64'(cc8), 64'd3);
    ifun8 = 4'd1; a8 = 8'h01; b8 = 8'h80;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_sub_result", 64'(result8), 64'h7F);
    check("w8_sub_cc", 64'(cc8), 64'd1);

    // random handshake run against the reference model
    m_valid = 1'b0; m_res = '0; m_err = 1'b0; m_cc = 3'b100;
    accepts = 0; cycles = 0;
    while (accepts < 100 && cycles < 3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      ifun      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                              : 4'($urandom_range(0, 3));
      a = pick_val(); b = pick_val(); set_cc = 1'($urandom_range(0, 1));
      #1;
      exp_acc = in_valid && (!m_valid || out_ready);
      check("rnd_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      @(posedge clk); #1;
      if (exp_acc) begin
        ref_op(ifun, a, b, r, e, fl);
        m_valid = 1'b1; m_res = r; m_err = e;
        if (set_cc && !e) m_cc = fl;
        accepts++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      check("rnd_out_valid", 64'(out_valid), 64'(m_valid));
      check("rnd_result", result, m_res);
      check("rnd_err", 64'(err), 64'(m_err));
      check("rnd_cc", 64'(cc), 64'(m_cc));
      cycles++;
    end
    in_valid = 1'b0;
    check("rnd_accept_count", 64'(accepts), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
